// File: rtl/uart_cmd_bridge.sv
// ASCII "wFPGA,<a>,<d>\n" / "rFPGA,<a>\n" parser acting as a bus master; reads answer in decimal text.
// Latency: we_o/re_o one cycle after '\n', first read digit ReadLatency+DataWidth+2 cycles after '\n'.
// Backpressure: tx bytes held until tx_ready_i; rx bytes dropped while busy_o; UART_CMD_BRIDGE_ACK_EN adds "OK\n" to writes.
module uart_cmd_bridge #(
  parameter int AddrWidth   = 16,
  parameter int DataWidth   = 32,
  parameter int ReadLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [AddrWidth-1:0] address_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 we_o,
  output logic                 re_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                 busy_o
);
  localparam int NDig = (DataWidth * 302 + 999) / 1000 + 1;
  localparam int IdxW = $clog2(NDig);
  localparam int CntW = $clog2(DataWidth + 1);
  localparam logic [7:0] ChNl    = 8'h0a;
  localparam logic [7:0] ChCr    = 8'h0d;
  localparam logic [7:0] ChComma = 8'h2c;

  typedef enum logic [3:0] {
    KEY, ADDR, DATA, WRITE, READ, RWAIT, CONV, SEND, ERR_DRAIN, ERR_SEND
`ifdef UART_CMD_BRIDGE_ACK_EN
    , ACK_SEND
`endif
  } state_t;

  state_t                state, state_n, err_to;
  logic [2:0]            key_idx;
  logic [7:0]            key_exp;
  logic                  op_wr, have_dig, rx_take, is_digit;
  logic [AddrWidth-1:0]  acc_addr;
  logic [DataWidth-1:0]  acc_data, shreg;
  logic [2:0]            lat_cnt;
  logic [CntW-1:0]       conv_cnt;
  logic [NDig*4-1:0]     bcd, bcd_adj;
  logic [IdxW-1:0]       dig_idx, first_nz, cur_idx;
  logic                  lead, nl_phase;
  logic [1:0]            msg_idx;

  assign rx_take  = rx_valid_i && (rx_data_i != ChCr);
  assign is_digit = (rx_data_i >= 8'h30) && (rx_data_i <= 8'h39);
  // A bad byte that is itself the line end must not wait for a second '\n'
  assign err_to   = (rx_data_i == ChNl) ? ERR_SEND : ERR_DRAIN;

  always_comb begin
    case (key_idx)
      3'd1:    key_exp = "F";
      3'd2:    key_exp = "P";
      3'd3:    key_exp = "G";
      3'd4:    key_exp = "A";
      default: key_exp = ",";
    endcase
  end

  always_comb begin
    bcd_adj  = bcd;
    first_nz = '0;
    for (int i = 0; i < NDig; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      if (bcd[i*4 +: 4] != 4'd0) first_nz = IdxW'(i);
    end
    // leading zeros are skipped in one step when the first digit goes out
    cur_idx = lead ? first_nz : dig_idx;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= KEY;
    else         state <= state_n;
  end

  always_comb begin
    state_n    = state;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    we_o       = 1'b0;
    re_o       = 1'b0;
    busy_o     = 1'b1;
    case (state)
      KEY: begin
        busy_o = 1'b0;
        if (rx_take) begin
          if (key_idx == 3'd0) begin
            if (rx_data_i != ChNl && rx_data_i != "w" && rx_data_i != "r") state_n = ERR_DRAIN;
          end else if (rx_data_i != key_exp) begin
            state_n = err_to;
          end else if (key_idx == 3'd5) begin
            state_n = ADDR;
          end
        end
      end
      ADDR: begin
        busy_o = 1'b0;
        if (rx_take && !is_digit) begin
          if (have_dig && op_wr && rx_data_i == ChComma)    state_n = DATA;
          else if (have_dig && !op_wr && rx_data_i == ChNl) state_n = READ;
          else                                              state_n = err_to;
        end
      end
      DATA: begin
        busy_o = 1'b0;
        if (rx_take && !is_digit) begin
          if (have_dig && rx_data_i == ChNl) state_n = WRITE;
          else                               state_n = err_to;
        end
      end
      WRITE: begin
        we_o = 1'b1;
`ifdef UART_CMD_BRIDGE_ACK_EN
        state_n = ACK_SEND;
`else
        state_n = KEY;
`endif
      end
      READ: begin
        re_o    = 1'b1;
        state_n = RWAIT;
      end
      RWAIT: if (lat_cnt == 3'(ReadLatency - 1)) state_n = CONV;
      CONV:  if (conv_cnt == CntW'(DataWidth - 1)) state_n = SEND;
      SEND: begin
        tx_valid_o = 1'b1;
        tx_data_o  = nl_phase ? ChNl : {4'h3, bcd[cur_idx*4 +: 4]};
        if (tx_ready_i && nl_phase) state_n = KEY;
      end
      ERR_DRAIN: begin
        busy_o = 1'b0;
        if (rx_valid_i && rx_data_i == ChNl) state_n = ERR_SEND;
      end
      ERR_SEND: begin
        tx_valid_o = 1'b1;
        case (msg_idx)
          2'd0:    tx_data_o = "E";
          2'd1,
          2'd2:    tx_data_o = "R";
          default: tx_data_o = ChNl;
        endcase
        if (tx_ready_i && msg_idx == 2'd3) state_n = KEY;
      end
`ifdef UART_CMD_BRIDGE_ACK_EN
      ACK_SEND: begin
        tx_valid_o = 1'b1;
        case (msg_idx)
          2'd0:    tx_data_o = "O";
          2'd1:    tx_data_o = "K";
          default: tx_data_o = ChNl;
        endcase
        if (tx_ready_i && msg_idx == 2'd2) state_n = KEY;
      end
`endif
      default: state_n = KEY;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      key_idx   <= '0;
      op_wr     <= 1'b0;
      have_dig  <= 1'b0;
      acc_addr  <= '0;
      acc_data  <= '0;
      address_o <= '0;
      data_o    <= '0;
      lat_cnt   <= '0;
      conv_cnt  <= '0;
      shreg     <= '0;
      bcd       <= '0;
      dig_idx   <= '0;
      lead      <= 1'b0;
      nl_phase  <= 1'b0;
      msg_idx   <= '0;
    end else begin
      msg_idx <= '0;
      case (state)
        KEY: begin
          acc_addr <= '0;
          acc_data <= '0;
          have_dig <= 1'b0;
          if (state_n != KEY) begin
            key_idx <= '0;
          end else if (rx_take && (key_idx != 3'd0 || rx_data_i != ChNl)) begin
            key_idx <= key_idx + 3'd1;
            if (key_idx == 3'd0) op_wr <= (rx_data_i == "w");
          end
        end
        ADDR: if (rx_take) begin
          if (is_digit) begin
            acc_addr <= acc_addr * AddrWidth'(10) + AddrWidth'(rx_data_i[3:0]);
            have_dig <= 1'b1;
          end else if (state_n == DATA) begin
            have_dig <= 1'b0;
          end else if (state_n == READ) begin
            address_o <= acc_addr;
          end
        end
        DATA: if (rx_take) begin
          if (is_digit) begin
            acc_data <= acc_data * DataWidth'(10) + DataWidth'(rx_data_i[3:0]);
            have_dig <= 1'b1;
          end else if (state_n == WRITE) begin
            address_o <= acc_addr;
            data_o    <= acc_data;
          end
        end
        READ: lat_cnt <= '0;
        RWAIT: begin
          lat_cnt <= lat_cnt + 3'd1;
          if (state_n == CONV) begin
            shreg    <= data_i;
            bcd      <= '0;
            conv_cnt <= '0;
          end
        end
        CONV: begin
          bcd      <= {bcd_adj[NDig*4-2:0], shreg[DataWidth-1]};
          shreg    <= shreg << 1;
          conv_cnt <= conv_cnt + CntW'(1);
          if (state_n == SEND) begin
            lead     <= 1'b1;
            nl_phase <= 1'b0;
          end
        end
        SEND: if (tx_ready_i) begin
          lead <= 1'b0;
          if (cur_idx == '0) nl_phase <= 1'b1;
          else               dig_idx  <= cur_idx - IdxW'(1);
        end
        ERR_SEND: msg_idx <= tx_ready_i ? msg_idx + 2'd1 : msg_idx;
`ifdef UART_CMD_BRIDGE_ACK_EN
        ACK_SEND: msg_idx <= tx_ready_i ? msg_idx + 2'd1 : msg_idx;
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Scoreboard bench for uart_cmd_bridge: directed command lines, expected bus events and tx bytes queued,
// a negedge monitor pops and compares whenever the DUT strobes the bus or hands over a tx byte.
`timescale 1ns/1ps
module tb_uart_cmd_bridge;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [7:0]    rx_data_i;
  logic          rx_valid_i;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i;
  logic [AW-1:0] address_o;
  logic [DW-1:0] data_o;
  logic          we_o;
  logic          re_o;
  logic [DW-1:0] data_i;
  logic          busy_o;

  uart_cmd_bridge #(.AddrWidth(AW), .DataWidth(DW), .ReadLatency(RL)) dut (
    .clk_i(clk), .reset_i(reset_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .address_o(address_o), .data_o(data_o), .we_o(we_o), .re_o(re_o),
    .data_i(data_i), .busy_o(busy_o)
  );

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } bus_ev_t;

  bus_ev_t       bus_q[$];
  logic [7:0]    tx_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            nl_cyc = 0;
  int            exp_first = 0;
  bit            first_armed = 1'b0;
  bit            slow_mode = 1'b0;
  bit            stall_prev = 1'b0;
  logic [7:0]    prev_dat = 8'h00;
  logic [DW-1:0] rd_val = '0;
  logic [3:0]    re_pipe = '0;
  int            stall = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // bus slave: read data is only valid on the cycle ReadLatency after re_o
  always @(posedge clk) re_pipe <= {re_pipe[2:0], re_o};
  assign data_i = re_pipe[RL-1] ? rd_val : 32'hA5A5_A5A5;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    bus_ev_t e;
    if (reset_i) begin
      stall_prev = 1'b0;
    end else begin
      if (we_o || re_o) begin
        check("bus_event_expected", 64'(bus_q.size() != 0), 64'd1);
        if (bus_q.size() != 0) begin
          e = bus_q.pop_front();
          check("bus_is_write", 64'(we_o), 64'(e.is_wr));
          check("bus_address", 64'(address_o), 64'(e.addr));
          if (we_o) check("bus_wdata", 64'(data_o), 64'(e.data));
          check("bus_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (tx_valid_o) begin
        if (first_armed) begin
          check("first_tx_cycle", 64'(cyc), 64'(exp_first));
          first_armed = 1'b0;
        end
        if (stall_prev) check("tx_stable", 64'(tx_data_o), 64'(prev_dat));
        if (tx_ready_i) begin
          check("tx_byte_expected", 64'(tx_q.size() != 0), 64'd1);
          if (tx_q.size() != 0) check("tx_byte", 64'(tx_data_o), 64'(tx_q.pop_front()));
        end
      end
      stall_prev = tx_valid_o && !tx_ready_i;
      prev_dat   = tx_data_o;
    end
  end

  initial begin
    tx_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!slow_mode) begin
        tx_ready_i = 1'b1;
        stall = 0;
      end else if (tx_valid_o && stall >= 50) begin
        tx_ready_i = 1'b1;
        stall = 0;
      end else begin
        tx_ready_i = 1'b0;
        stall = tx_valid_o ? stall + 1 : 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    if (b == 8'h0a) nl_cyc = cyc;
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic push_tx(input string s);
    for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(posedge clk); #1;
    while (busy_o && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("return_to_idle", 64'(busy_o), 64'd0);
  endtask

  task automatic do_write(input string s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    send_str(s);
    bus_q.push_back('{1'b1, a, d, nl_cyc + 1});
`ifdef UART_CMD_BRIDGE_ACK_EN
    push_tx("OK\n");
`endif
    wait_idle();
  endtask

  task automatic start_read(input string s, input logic [AW-1:0] a, input logic [DW-1:0] v, input string rsp);
    rd_val = v;
    send_str(s);
    bus_q.push_back('{1'b0, a, '0, nl_cyc + 1});
    push_tx(rsp);
    exp_first   = nl_cyc + 2 + RL + DW;
    first_armed = 1'b1;
  endtask

  initial begin
    int n;
    reset_i    = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    #1;
    check("rst_tx_data", 64'(tx_data_o), 64'd0);
    check("rst_tx_valid", 64'(tx_valid_o), 64'd0);
    check("rst_we", 64'(we_o), 64'd0);
    check("rst_re", 64'(re_o), 64'd0);
    check("rst_address", 64'(address_o), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;

    do_write("wFPGA,36868,305419896\n", 16'd36868, 32'h1234_5678);
    start_read("rFPGA,36864\n", 16'd36864, 32'hFFFF_FFFF, "4294967295\n");
    wait_idle();
    check("hold_data_after_read", 64'(data_o), 64'h1234_5678);
    start_read("rFPGA,36864\n", 16'd36864, 32'd0, "0\n");
    wait_idle();
    do_write("wFPGA,0,4294967296\n", 16'd0, 32'd0);
    start_read("rFPGA,70000\n", 16'd4464, 32'd1234, "1234\n");
    wait_idle();
    check("hold_address", 64'(address_o), 64'd4464);
    check("hold_data", 64'(data_o), 64'd0);

    send_str("\n");
    wait_idle();
    send_str("xFPGA,1\n");
    push_tx("ERR\n");
    wait_idle();
    send_str("rFPGA,\n");
    push_tx("ERR\n");
    wait_idle();
    send_str("wFPGA,1\n");
    push_tx("ERR\n");
    wait_idle();

    slow_mode = 1'b1;
    start_read("rFPGA,12\n", 16'd12, 32'd1000200, "1000200\n");
    send_str("wFPGA,1,1\n");
    wait_idle();
    slow_mode = 1'b0;

    slow_mode = 1'b1;
    start_read("rFPGA,100\n", 16'd100, 32'd123, "");
    n = 0;
    while (!tx_valid_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_reached", 64'(tx_valid_o), 64'd1);
    #2 reset_i = 1'b1;
    #1;
    check("arst_tx_valid", 64'(tx_valid_o), 64'd0);
    check("arst_tx_data", 64'(tx_data_o), 64'd0);
    check("arst_address", 64'(address_o), 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    tx_q.delete();
    first_armed = 1'b0;
    slow_mode   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;

    start_read("rFPGA,4\r\n", 16'd4, 32'd4, "4\n");
    wait_idle();
    do_write("wFPGA,7,9\n", 16'd7, 32'd9);
    repeat (5) @(posedge clk);
    #1;
    check("final_address", 64'(address_o), 64'd7);
    check("final_data", 64'(data_o), 64'd9);
    check("tx_queue_drained", 64'(tx_q.size()), 64'd0);
    check("bus_queue_drained", 64'(bus_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
